// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller.
// Turns load-use, taken-branch and data-memory wait conditions into stage
// register enables, flushes and bubbles for a five-stage pipeline. A memory
// access that stays unacknowledged for too long locks the pipeline in an
// error state that only reset clears.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  id_rn,
  input  logic [3:0]  id_rm,
  input  logic        id_use_rn,
  input  logic        id_use_rm,
  input  logic [3:0]  ex_rd,
  input  logic        ex_load,
  input  logic        ex_reg_write_enable,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_enable,
  output logic        if_id_enable,
  output logic        id_ex_enable,
  output logic        ex_mem_enable,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        mem_wb_bubble,
  output logic        mem_error,
  output logic [15:0] stall_cycles
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  localparam logic [7:0] TIMEOUT_C = MEM_TIMEOUT[7:0];

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic [7:0]  wait_cnt_r;
  logic [7:0]  wait_cnt_nxt_s;
  logic [15:0] stall_cycles_r;
  logic        mem_error_r;

  logic        load_use_s;
  logic        mem_stall_s;
  logic        pc_enable_s;
  logic        if_id_enable_s;
  logic        id_ex_enable_s;
  logic        ex_mem_enable_s;
  logic        if_id_flush_s;
  logic        id_ex_bubble_s;
  logic        mem_wb_bubble_s;

  // Hazard detection: ID source matches a pending load destination in EX.
  always_comb begin
    load_use_s = ex_load & ex_reg_write_enable &
                 ((id_use_rn & (id_rn == ex_rd)) | (id_use_rm & (id_rm == ex_rd)));
  end

  // Memory stall: a fresh unacknowledged request in RUN, or still no ack in MEM_WAIT.
  always_comb begin
    mem_stall_s = 1'b0;
    case (state_r)
      ST_RUN:      mem_stall_s = mem_req & ~mem_ack;
      ST_MEM_WAIT: mem_stall_s = ~mem_ack;
      default:     mem_stall_s = 1'b0;
    endcase
  end

  // Stage control decode, priority mem_stall > branch > load_use; all quiet in reset/ERROR.
  always_comb begin
    pc_enable_s     = 1'b0;
    if_id_enable_s  = 1'b0;
    id_ex_enable_s  = 1'b0;
    ex_mem_enable_s = 1'b0;
    if_id_flush_s   = 1'b0;
    id_ex_bubble_s  = 1'b0;
    mem_wb_bubble_s = 1'b0;
    if (!reset) begin
      pc_enable_s = 1'b0;
    end else begin
      case (state_r)
        ST_RUN, ST_MEM_WAIT: begin
          if (mem_stall_s) begin
            mem_wb_bubble_s = 1'b1;
          end else if (branch_taken) begin
            pc_enable_s     = 1'b1;
            if_id_enable_s  = 1'b1;
            id_ex_enable_s  = 1'b1;
            ex_mem_enable_s = 1'b1;
            if_id_flush_s   = 1'b1;
            id_ex_bubble_s  = 1'b1;
          end else if (load_use_s) begin
            id_ex_enable_s  = 1'b1;
            ex_mem_enable_s = 1'b1;
            id_ex_bubble_s  = 1'b1;
          end else begin
            pc_enable_s     = 1'b1;
            if_id_enable_s  = 1'b1;
            id_ex_enable_s  = 1'b1;
            ex_mem_enable_s = 1'b1;
          end
        end
        default: begin
          pc_enable_s = 1'b0;
        end
      endcase
    end
  end

  // Next-state and wait-counter logic; an unknown encoding falls into ERROR.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    case (state_r)
      ST_RUN: begin
        if (mem_req && !mem_ack) begin
          state_nxt_s    = ST_MEM_WAIT;
          wait_cnt_nxt_s = 8'd0;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack) begin
          state_nxt_s = ST_RUN;
        end else if (({1'b0, wait_cnt_r} + 9'd1) >= {1'b0, TIMEOUT_C}) begin
          state_nxt_s    = ST_ERROR;
          wait_cnt_nxt_s = wait_cnt_r + 8'd1;
        end else begin
          state_nxt_s    = ST_MEM_WAIT;
          wait_cnt_nxt_s = wait_cnt_r + 8'd1;
        end
      end
      ST_ERROR: begin
        state_nxt_s = ST_ERROR;
      end
      default: begin
        state_nxt_s = ST_ERROR;
      end
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Sticky error flag, set on the edge that enters ERROR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_error_r <= 1'b0;
    end else begin
      mem_error_r <= mem_error_r | (state_nxt_s == ST_ERROR);
    end
  end

  // Saturating count of cycles where the PC was held outside ERROR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_r <= 16'd0;
    end else if (!pc_enable_s && (state_r != ST_ERROR) && (stall_cycles_r != 16'hFFFF)) begin
      stall_cycles_r <= stall_cycles_r + 16'd1;
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  assign pc_enable     = pc_enable_s;
  assign if_id_enable  = if_id_enable_s;
  assign id_ex_enable  = id_ex_enable_s;
  assign ex_mem_enable = ex_mem_enable_s;
  assign if_id_flush   = if_id_flush_s;
  assign id_ex_bubble  = id_ex_bubble_s;
  assign mem_wb_bubble = mem_wb_bubble_s;
  assign mem_error     = mem_error_r;
  assign stall_cycles  = stall_cycles_r;

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: max consecutive memory-wait cycles before error (range 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports id_rn, id_rm  input  4 each  source register numbers of the instruction in ID.
REQ-005 SHALL have ports id_use_rn, id_use_rm  input  1 each  ID instruction reads rn / rm.
REQ-006 SHALL have ports ex_rd  input  4, ex_load  input  1, ex_reg_write_enable  input  1  destination, load flag and write enable of the instruction in EX.
REQ-007 SHALL have port branch_taken  input  1  branch resolved taken in EX.
REQ-008 SHALL have ports mem_req  input  1, mem_ack  input  1  data-memory request from the MEM stage and its completion.
REQ-009 SHALL have outputs pc_enable, if_id_enable, id_ex_enable, ex_mem_enable  1 each  stage-register load enables (1 = advance).
REQ-010 SHALL have outputs if_id_flush, id_ex_bubble, mem_wb_bubble  1 each  insert a NOP into that register on this edge.
REQ-011 SHALL have outputs mem_error  1  sticky timeout flag; stall_cycles  16  saturating count of stalled cycles.

Function
REQ-012 SHALL implement FSM states RUN, MEM_WAIT, ERROR; reset state RUN.
REQ-013 SHALL define load_use = ex_load & ex_reg_write_enable & ((id_use_rn & id_rn==ex_rd) | (id_use_rm & id_rm==ex_rd)).
REQ-014 SHALL define mem_stall = mem_req & ~mem_ack in RUN, and ~mem_ack in MEM_WAIT.
REQ-015 SHALL apply priority mem_stall > branch_taken > load_use; lower-priority events are not acted on while a higher one is active.
REQ-016 SHALL, in RUN with no event: all four enables 1, all flush/bubble 0.
REQ-017 SHALL, on mem_stall (RUN or MEM_WAIT): all four enables 0, mem_wb_bubble 1, other flush/bubble 0.
REQ-018 SHALL, on branch_taken without mem_stall: all enables 1, if_id_flush 1, id_ex_bubble 1.
REQ-019 SHALL, on load_use without branch or mem_stall: pc_enable 0, if_id_enable 0, id_ex_enable 1, id_ex_bubble 1, ex_mem_enable 1; exactly one bubble per hazard.
REQ-020 SHALL transition RUN->MEM_WAIT when mem_req=1 and mem_ack=0; MEM_WAIT->RUN on the edge where mem_ack=1; outputs in that ack cycle follow RUN rules (REQ-016..019).
REQ-021 SHALL count wait cycles in an 8-bit counter cleared on entering MEM_WAIT and incremented each MEM_WAIT cycle; when the counter reaches MEM_TIMEOUT with mem_ack=0 the FSM SHALL go to ERROR.
REQ-022 SHALL, in ERROR: all enables 0, all flush/bubble 0, mem_error 1; exit only by reset.
REQ-023 SHALL increment stall_cycles on every cycle where pc_enable=0 and not in ERROR, saturating at 16'hFFFF.
REQ-024 SHALL treat mem_req and mem_ack simultaneously 1 in RUN as zero-wait: no stall, state stays RUN.
REQ-025 SHALL rely on EX being frozen during MEM_WAIT, so branch_taken/load_use held stable are acted on in the ack cycle; no event is latched internally.

Reset
REQ-026 SHALL, while reset=0: state RUN, wait counter 0, stall_cycles 0, mem_error 0, all enables 0, all flush/bubble 0.
REQ-027 SHALL, on reset assertion mid MEM_WAIT or ERROR, return to RUN immediately; first edge after release behaves per RUN rules.

Verification
REQ-028 SHALL verify load-use: ex_load=1, ex_reg_write_enable=1, ex_rd=3, id_rn=3, id_use_rn=1 -> one cycle pc_enable=0, if_id_enable=0, id_ex_bubble=1; stall_cycles 0->1.
REQ-029 SHALL verify branch: branch_taken=1 with concurrent load_use -> if_id_flush=1, id_ex_bubble=1, pc_enable=1, stall_cycles unchanged.
REQ-030 SHALL verify memory wait: mem_req=1, mem_ack=0 for 3 cycles then 1 -> enables 0 and mem_wb_bubble=1 for 3 cycles, RUN on 4th edge, stall_cycles=3.
REQ-031 SHALL verify timeout: MEM_TIMEOUT=4, mem_ack held 0 -> ERROR after 4 MEM_WAIT cycles, mem_error=1 sticky, all enables 0 until reset.
REQ-032 SHALL verify zero-wait access: mem_req=1, mem_ack=1 same cycle -> no stall, state RUN.
REQ-033 SHALL verify async reset: reset driven low between clock edges in MEM_WAIT -> outputs per REQ-026 without a clock edge; RUN after release.
